arya_mem_loader: RTL and testbench

Host-side loader that sits directly upstream of the `arya` core's memory debug port. It receives a byte stream over a valid/ready handshake, packs every 8 bytes into a 64-bit word, and writes the words sequentially into unified memory through `mem_addr_in`/`mem_data_in`/`setup_mem`. It then accepts the same stream a second time, reads each word back via `verify_mem`/`mem_data_out` and compares. The core is held in reset until the image verifies clean.

---
 rtl/arya_loader_pkg.sv | 21 ++
 rtl/arya_mem_loader_packer.sv | 46 ++++
 rtl/arya_mem_loader.sv | 153 +++++++++++++++
 tb/tb_arya_mem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arya_loader_pkg.sv
`default_nettype none
// arya_loader_pkg: shared types and sizes for the arya memory loader.
// Rev 1.0
package arya_loader_pkg;
  localparam int BYTES_PER_WORD = 8;
  localparam int MEM_ADDR_W     = 10;
  localparam int DATA_W         = 64;
  localparam int CNT_W          = 11;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_LOAD_COLLECT = 3'd1,
    S_LOAD_WRITE   = 3'd2,
    S_VER_COLLECT  = 3'd3,
    S_VER_READ     = 3'd4,
    S_VER_CMP      = 3'd5,
    S_DONE         = 3'd6,
    S_FAIL         = 3'd7
  } loader_state_e;
endpackage
`default_nettype wire

// File: rtl/arya_mem_loader_packer.sv
`default_nettype none
// byte_word_packer: gathers 8 stream bytes into a little-endian 64-bit word.
// Rev 1.0
module byte_word_packer
  import arya_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              strobe,
  input  logic              clear,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (strobe) begin
      word_d[{cnt_q, 3'b000} +: 8] = in_byte;
      cnt_d                        = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Word includes the byte arriving this cycle so the completed word is usable immediately.
  assign word      = word_d;
  assign word_full = strobe && !clear && (cnt_q == 3'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/arya_mem_loader.sv
`default_nettype none
// arya_mem_loader: writes a byte-streamed image into arya memory, re-reads it
// against a second pass of the stream and releases cpu_hold once it matches. Rev 1.0
module arya_mem_loader
  import arya_loader_pkg::*;
#(
  parameter int LOAD_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  setup_mem,
  output logic                  verify_mem,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [MEM_ADDR_W-1:0] error_addr
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(LOAD_WORDS - 1);

  loader_state_e         state_q, state_d;
  logic [CNT_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [MEM_ADDR_W-1:0] error_addr_q, error_addr_d;
  logic in_ready_q, in_ready_d;
  logic setup_mem_q, setup_mem_d;
  logic verify_mem_q, verify_mem_d;
  logic cpu_hold_q, cpu_hold_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic              byte_xfer;
  logic              pack_clear;
  logic              word_full;
  logic [DATA_W-1:0] pack_word;

  assign byte_xfer = in_valid && in_ready_q;

  byte_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_data),
    .strobe    (byte_xfer),
    .clear     (pack_clear),
    .word      (pack_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_wdata_d  = mem_wdata_q;
    error_addr_d = error_addr_q;
    error_d      = error_q;
    pack_clear   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d    = S_LOAD_COLLECT;
          addr_d     = '0;
          error_d    = 1'b0;
          pack_clear = 1'b1;
        end
      end
      S_LOAD_COLLECT: begin
        if (word_full) begin
          state_d     = S_LOAD_WRITE;
          mem_wdata_d = pack_word;
        end
      end
      S_LOAD_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_VER_COLLECT;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD_COLLECT;
        end
      end
      S_VER_COLLECT: begin
        if (word_full) state_d = S_VER_READ;
      end
      S_VER_READ: state_d = S_VER_CMP;
      S_VER_CMP: begin
        // Read data returns one cycle after the verify strobe, i.e. now.
        if (mem_rdata != pack_word) begin
          error_addr_d = addr_q[MEM_ADDR_W-1:0];
          error_d      = 1'b1;
          state_d      = S_FAIL;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_VER_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered by decoding the next state.
    in_ready_d   = (state_d == S_LOAD_COLLECT) || (state_d == S_VER_COLLECT);
    setup_mem_d  = (state_d == S_LOAD_WRITE);
    verify_mem_d = (state_d == S_VER_READ);
    done_d       = (state_d == S_DONE);
    cpu_hold_d   = (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      mem_wdata_q  <= '0;
      error_addr_q <= '0;
      in_ready_q   <= 1'b0;
      setup_mem_q  <= 1'b0;
      verify_mem_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_wdata_q  <= mem_wdata_d;
      error_addr_q <= error_addr_d;
      in_ready_q   <= in_ready_d;
      setup_mem_q  <= setup_mem_d;
      verify_mem_q <= verify_mem_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_addr   = addr_q[MEM_ADDR_W-1:0];
  assign mem_wdata  = mem_wdata_q;
  assign setup_mem  = setup_mem_q;
  assign verify_mem = verify_mem_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_addr = error_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_arya_mem_loader.sv
`default_nettype none
// tb_arya_mem_loader: table-driven image loads with a write/read scoreboard,
// plus reset-abort, ignored-start and a 1024-word run with random valid gaps.
module tb_arya_mem_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int         flip_idx;
    logic [7:0] flip_val;
    bit         mid_start;
    bit         exp_done;
    bit         exp_err;
    logic [9:0] exp_eaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;

  logic        s_in_ready, s_setup, s_verify, s_cpu_hold, s_done, s_error;
  logic [9:0]  s_addr, s_error_addr;
  logic [63:0] s_wdata;
  logic [63:0] s_rdata = '0;

  logic        b_in_ready, b_setup, b_verify, b_cpu_hold, b_done, b_error;
  logic [9:0]  b_addr, b_error_addr;
  logic [63:0] b_wdata;
  logic [63:0] b_rdata = '0;

  logic [63:0] smem [1024];
  logic [63:0] bmem [1024];
  logic [7:0]  bigimg [8192];

  wr_t        wr_q [$];
  logic [9:0] rd_q [$];

  int  total = 0;
  int  bad = 0;
  bit  mon_small = 1'b0;
  bit  mon_big = 1'b0;
  int  big_wr_cnt = 0;
  int  big_rd_cnt = 0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  arya_mem_loader #(.LOAD_WORDS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .mem_addr(s_addr), .mem_wdata(s_wdata), .setup_mem(s_setup),
    .verify_mem(s_verify), .mem_rdata(s_rdata), .cpu_hold(s_cpu_hold), .done(s_done),
    .error(s_error), .error_addr(s_error_addr)
  );

  arya_mem_loader #(.LOAD_WORDS(1024)) u_big (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mem_addr(b_addr), .mem_wdata(b_wdata), .setup_mem(b_setup),
    .verify_mem(b_verify), .mem_rdata(b_rdata), .cpu_hold(b_cpu_hold), .done(b_done),
    .error(b_error), .error_addr(b_error_addr)
  );

  // Memory models standing in for the core's debug port.
  always @(posedge clk) begin
    if (s_setup) smem[s_addr] <= s_wdata;
    if (s_verify) s_rdata <= smem[s_addr];
    if (b_setup) bmem[b_addr] <= b_wdata;
    if (b_verify) b_rdata <= bmem[b_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] img_word(input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8*k + j);
    return w;
  endfunction

  function automatic logic [63:0] big_word(input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = bigimg[8*k + j];
    return w;
  endfunction

  always @(negedge clk) begin : mon_small_b
    wr_t        e;
    logic [9:0] ra;
    if (!reset && mon_small) begin
      if (s_setup || s_verify) chk("strobe_overlap", 64'(s_setup & s_verify), 0);
      if (s_setup) begin
        chk("wr_expected", 64'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("wr_addr", 64'(s_addr), 64'(e.addr));
          chk("wr_data", s_wdata, e.data);
        end
      end
      if (s_verify) begin
        chk("rd_expected", 64'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          ra = rd_q.pop_front();
          chk("rd_addr", 64'(s_addr), 64'(ra));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && mon_big) begin
      if (b_setup) begin
        chk("big_wr_addr", 64'(b_addr), 64'(big_wr_cnt));
        if (big_wr_cnt < 1024) chk("big_wr_data", b_wdata, big_word(big_wr_cnt));
        big_wr_cnt++;
      end
      if (b_verify) begin
        chk("big_rd_addr", 64'(b_addr), 64'(big_rd_cnt));
        big_rd_cnt++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit big, input bit gaps);
    int guard;
    bit rdy;
    guard = 0;
    if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      rdy = big ? b_in_ready : s_in_ready;
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 40) begin
        chk("byte_accept", 64'(rdy), 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(s_in_ready), 0);
    chk({tag, "_setup"}, 64'(s_setup), 0);
    chk({tag, "_verify"}, 64'(s_verify), 0);
    chk({tag, "_done"}, 64'(s_done), 0);
    chk({tag, "_error"}, 64'(s_error), 0);
    chk({tag, "_addr"}, 64'(s_addr), 0);
    chk({tag, "_wdata"}, s_wdata, 0);
    chk({tag, "_err_addr"}, 64'(s_error_addr), 0);
    chk({tag, "_hold"}, 64'(s_cpu_hold), 1);
  endtask

  task automatic run_case(input vec_t v);
    int         nb;
    logic [7:0] b;
    pulse_start();
    chk("start_err_clear", 64'(s_error), 0);
    chk("start_done_clear", 64'(s_done), 0);
    chk("start_ready", 64'(s_in_ready), 1);
    chk("start_hold", 64'(s_cpu_hold), 1);
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 7) wr_q.push_back('{addr: 10'(i / 8), data: img_word(i / 8)});
      send_byte(8'(i), 1'b0, 1'b0);
      if (v.mid_start && i == 2) pulse_start();
    end
    nb = (v.flip_idx < 0) ? 32 : (v.flip_idx / 8 + 1) * 8;
    for (int i = 0; i < nb; i++) begin
      b = (i == v.flip_idx) ? v.flip_val : 8'(i);
      if (i % 8 == 7) rd_q.push_back(10'(i / 8));
      send_byte(b, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("early_done", 64'(s_done), 0);
    chk("early_err", 64'(s_error), 0);
    @(negedge clk);
    chk("final_done", 64'(s_done), 64'(v.exp_done));
    chk("final_err", 64'(s_error), 64'(v.exp_err));
    chk("final_hold", 64'(s_cpu_hold), 64'(!v.exp_done));
    chk("final_ready", 64'(s_in_ready), 0);
    if (v.exp_err) chk("err_addr", 64'(s_error_addr), 64'(v.exp_eaddr));
    chk("wr_q_drained", 64'(wr_q.size()), 0);
    chk("rd_q_drained", 64'(rd_q.size()), 0);
  endtask

  initial begin
    vecs[0] = '{-1, 8'h00, 1'b0, 1'b1, 1'b0, 10'd0};
    vecs[1] = '{10, 8'hFF, 1'b0, 1'b0, 1'b1, 10'd1};
    vecs[2] = '{-1, 8'h00, 1'b1, 1'b1, 1'b0, 10'd0};
    vecs[3] = '{0,  8'h55, 1'b0, 1'b0, 1'b1, 10'd0};
    vecs[4] = '{31, 8'h00, 1'b1, 1'b0, 1'b1, 10'd3};
    vecs[5] = '{23, 8'hAA, 1'b0, 1'b0, 1'b1, 10'd2};
    vecs[6] = '{-1, 8'h00, 1'b0, 1'b1, 1'b0, 10'd0};
    for (int i = 0; i < 8192; i++) bigimg[i] = 8'($urandom);

    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(s_in_ready), 0);
    mon_small = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i]);
      if (i == 0) begin
        chk("mem_word0", smem[0], 64'h0706050403020100);
        chk("mem_word3", smem[3], 64'h1F1E1D1C1B1A1918);
      end
    end

    // Abort partway into word 2, then reload from scratch.
    pulse_start();
    for (int i = 0; i < 21; i++) begin
      if (i % 8 == 7) wr_q.push_back('{addr: 10'(i / 8), data: img_word(i / 8)});
      send_byte(8'(i), 1'b0, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    chk("abort_wr_q", 64'(wr_q.size()), 0);
    reset = 1'b0;
    @(negedge clk);
    run_case(vecs[0]);

    mon_small = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_big = 1'b1;
    pulse_start();
    for (int i = 0; i < 8192; i++) send_byte(bigimg[i], 1'b1, 1'b1);
    for (int i = 0; i < 8192; i++) send_byte(bigimg[i], 1'b1, 1'b1);
    for (int i = 0; i < 10 && !b_done; i++) @(negedge clk);
    chk("big_done", 64'(b_done), 1);
    chk("big_hold", 64'(b_cpu_hold), 0);
    chk("big_err", 64'(b_error), 0);
    chk("big_writes", 64'(big_wr_cnt), 1024);
    chk("big_reads", 64'(big_rd_cnt), 1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
